// File: rtl/add16_pkg.sv
// Shared types and constants for the two-stage 16-bit lookahead adder.
// The stage-1 record carries per-bit generate/propagate plus carry-in.
package add16_pkg;

    localparam int WIDTH    = 16;
    localparam int GROUP_W  = 4;
    localparam int N_GROUPS = 4;

    typedef struct packed {
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic             cin;
    } s1_t;

endpackage

// File: rtl/add16_pipe_cla.sv
// Four-bit carry-lookahead cell: carries C1..C4 plus group G/P.
// Used both per nibble and once across the four nibble groups.
module add16_pipe_cla (
    input  logic [3:0] g,
    input  logic [3:0] p,
    input  logic       cin,
    output logic [4:1] c,
    output logic       gg,
    output logic       pg
);

    // Flat two-level carry equations, no ripple between positions
    always_comb begin
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
        pg   = &p;
    end

endmodule

// File: rtl/add16_pipe.sv
// Two-stage pipelined 16-bit adder with valid/ready flow control.
// Stage 1 holds g/p/cin; stage 2 resolves carries into the output register.
module add16_pipe
    import add16_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    s1_t              s1_q, s1_d;
    logic             s1_vld_q, s1_vld_d;
    logic             out_vld_q, out_vld_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             s2_load;
    logic             in_xfer;

    logic [N_GROUPS-1:0]       nib_g;
    logic [N_GROUPS-1:0]       nib_p;
    logic [N_GROUPS-1:0]       nib_cin;
    logic [N_GROUPS-1:0][4:1]  nib_c;
    logic [4:1]                grp_c;
    logic                      grp_g;
    logic                      grp_p;
    logic [WIDTH-1:0]          carry;
    logic [WIDTH-1:0]          sum_comb;
    logic                      cout_comb;
    logic                      ovf_comb;
    logic                      unused_carries;

    // Nibble-level lookahead over the registered g/p
    for (genvar k = 0; k < N_GROUPS; k++) begin : g_nib
        add16_pipe_cla u_nib (
            .g   (s1_q.g[k*GROUP_W +: GROUP_W]),
            .p   (s1_q.p[k*GROUP_W +: GROUP_W]),
            .cin (nib_cin[k]),
            .c   (nib_c[k]),
            .gg  (nib_g[k]),
            .pg  (nib_p[k])
        );
    end

    // Second level: nibble carry-ins from group G/P and cin
    add16_pipe_cla u_grp (
        .g   (nib_g),
        .p   (nib_p),
        .cin (s1_q.cin),
        .c   (grp_c),
        .gg  (grp_g),
        .pg  (grp_p)
    );

    // Carry vector, sum and flags; carries out of nibbles come from u_grp
    always_comb begin
        nib_cin = {grp_c[3:1], s1_q.cin};
        carry   = '0;
        for (int k = 0; k < N_GROUPS; k++) begin
            carry[k*GROUP_W]           = nib_cin[k];
            carry[k*GROUP_W+1 +: 3]    = nib_c[k][3:1];
        end
        sum_comb  = s1_q.p ^ carry;
        cout_comb = grp_c[4];
        ovf_comb  = carry[WIDTH-1] ^ grp_c[4];
        unused_carries = ^{nib_c[0][4], nib_c[1][4], nib_c[2][4],
                           nib_c[3][4], grp_g, grp_p};
    end

    // Handshake and next-state: each stage loads when its successor frees
    always_comb begin
        s2_load   = s1_vld_q & (~out_vld_q | out_ready);
        in_ready  = rst_n & (~s1_vld_q | s2_load);
        in_xfer   = in_valid & in_ready;

        s1_vld_d  = in_xfer | (s1_vld_q & ~s2_load);
        s1_d      = s1_q;
        if (in_xfer) begin
            s1_d.g   = in_a & in_b;
            s1_d.p   = in_a ^ in_b;
            s1_d.cin = in_cin;
        end

        out_vld_d = s2_load | (out_vld_q & ~out_ready);
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        if (s2_load) begin
            sum_d  = sum_comb;
            cout_d = cout_comb;
            ovf_d  = ovf_comb;
        end
    end

    // All pipeline state; synchronous active-low reset flushes everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s1_vld_q  <= 1'b0;
            out_vld_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s1_vld_q  <= s1_vld_d;
            out_vld_q <= out_vld_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign out_valid = out_vld_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_add16_pipe.sv
// Scoreboard bench for add16_pipe: driver pushes expected results,
// a negedge monitor pops and compares on every output transfer.
module tb_add16_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        out_ovf;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [17:0] exp_q[$];
    int          pop_log[$];

    add16_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] model(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic c);
        logic [16:0] s;
        logic        v;
        s = {1'b0, a} + {1'b0, b} + {16'd0, c};
        v = (a[15] == b[15]) && (s[15] != a[15]);
        return {s[15:0], s[16], v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands; push the expected result on the accepting edge
    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic [17:0] e);
        in_a     = a;
        in_b     = b;
        in_cin   = c;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                tick();
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: in_ready got 0 want 1");
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        chk("drain_left", exp_q.size(), 0);
    endtask

    // Monitor: compare on output transfers, and check hold while stalled
    initial begin
        logic        held_v;
        logic [17:0] held;
        held_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (held_v)
                chk("stall_hold", {out_valid, out_sum, out_cout, out_ovf},
                    {1'b1, held});
            held_v = rst_n && out_valid && !out_ready;
            held   = {out_sum, out_cout, out_ovf};
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got %h want none",
                             {out_sum, out_cout, out_ovf});
                end else begin
                    chk("result", {out_sum, out_cout, out_ovf},
                        exp_q.pop_front());
                    pop_log.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got stuck want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_data", {out_sum, out_cout, out_ovf}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_ready", in_ready, 1);
        tick();

        // Wrap to zero with carry; result two edges after presentation
        send(16'hFFFF, 16'h0001, 1'b0, {16'h0000, 1'b1, 1'b0});
        chk("lat_edge1", out_valid, 0);
        tick();
        chk("lat_edge2", out_valid, 1);
        chk("lat_data", {out_sum, out_cout, out_ovf},
            {16'h0000, 1'b1, 1'b0});
        drain();

        // Overflow corners and carry-in only
        send(16'h7FFF, 16'h0001, 1'b0, {16'h8000, 1'b0, 1'b1});
        send(16'h8000, 16'h8000, 1'b0, {16'h0000, 1'b1, 1'b1});
        send(16'h0000, 16'h0000, 1'b1, {16'h0001, 1'b0, 1'b0});
        drain();

        // Back-to-back: three results on consecutive cycles
        tick();
        pop_log.delete();
        send(16'h1234, 16'h1111, 1'b0, {16'h2345, 1'b0, 1'b0});
        send(16'h00FF, 16'h0001, 1'b0, {16'h0100, 1'b0, 1'b0});
        send(16'hFFFF, 16'hFFFF, 1'b1, {16'hFFFF, 1'b1, 1'b0});
        drain();
        chk("b2b_count", pop_log.size(), 3);
        if (pop_log.size() == 3) begin
            chk("b2b_gap1", pop_log[1] - pop_log[0], 1);
            chk("b2b_gap2", pop_log[2] - pop_log[1], 1);
        end

        // Backpressure: two accepts fill the pipe, then hold
        out_ready = 1'b0;
        send(16'h0001, 16'h0002, 1'b0, {16'h0003, 1'b0, 1'b0});
        send(16'h4000, 16'h4000, 1'b0, {16'h8000, 1'b0, 1'b1});
        in_a     = 16'h0F0F;
        in_b     = 16'hF0F0;
        in_cin   = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            tick();
        end
        chk("stall_sum", out_sum, 16'h0003);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(16'h0F0F, 16'hF0F0, 1'b1, {16'h0000, 1'b1, 1'b0});
        drain();

        // Reset with two transfers in flight
        out_ready = 1'b0;
        send(16'hAAAA, 16'h5555, 1'b0, {16'hFFFF, 1'b0, 1'b0});
        send(16'h1111, 16'h2222, 1'b0, {16'h3333, 1'b0, 1'b0});
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 0);
        tick();
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_data", {out_sum, out_cout, out_ovf}, 0);
        exp_q.delete();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(16'h0100, 16'h0200, 1'b0, {16'h0300, 1'b0, 1'b0});
        chk("post_rst_lat1", out_valid, 0);
        tick();
        chk("post_rst_lat2", out_valid, 1);
        chk("post_rst_data", {out_sum, out_cout, out_ovf},
            {16'h0300, 1'b0, 1'b0});
        drain();

        // Random traffic with random backpressure
        acc = 0;
        for (int c = 0; c < 60000 && acc < 10000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = 16'($urandom);
            in_b      = 16'($urandom);
            in_cin    = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_a, in_b, in_cin));
                acc++;
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("rand_accepted", acc, 10000);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
